// File: rtl/dwc_upconv_rchan_beat_sequencer_if.sv
// Handshake bundle between the read-data beat sequencer, the pre-calc command slice,
// the wide read-data FIFO and the narrow master R channel.
interface dwc_upconv_rchan_beat_sequencer_if #(
  parameter int ID_WIDTH = 4
);
  logic                cmd_empty;
  logic                cmd_rd_en;
  logic [9:0]          cmd_addr;
  logic [ID_WIDTH-1:0] cmd_id;
  logic [7:0]          cmd_len;
  logic                cmd_fixed;
  logic                cmd_wrap;
  logic [4:0]          cmd_to_wrap;
  logic [9:0]          cmd_mask;
  logic [5:0]          cmd_src_top;
  logic                slv_data_valid;
  logic                slv_data_pop;
  logic [5:0]          rd_src;
  logic                mst_rvalid;
  logic                mst_rready;
  logic                mst_rlast;
  logic [ID_WIDTH-1:0] mst_rid;

  // master: the sequencer itself; slave: the surrounding slice/FIFO/master side
  modport master (
    input  cmd_empty, cmd_addr, cmd_id, cmd_len, cmd_fixed, cmd_wrap,
           cmd_to_wrap, cmd_mask, cmd_src_top, slv_data_valid, mst_rready,
    output cmd_rd_en, slv_data_pop, rd_src, mst_rvalid, mst_rlast, mst_rid
  );

  modport slave (
    output cmd_empty, cmd_addr, cmd_id, cmd_len, cmd_fixed, cmd_wrap,
           cmd_to_wrap, cmd_mask, cmd_src_top, slv_data_valid, mst_rready,
    input  cmd_rd_en, slv_data_pop, rd_src, mst_rvalid, mst_rlast, mst_rid
  );
endinterface

// File: rtl/dwc_upconv_rchan_beat_sequencer.sv
// Read-data beat sequencer for the AXI4 width up-converter: walks one master burst per command.
// Optional macro DWC_UPCONV_RSEQ_STALL_CNT_EN enables the saturating stall counter.
module dwc_upconv_rchan_beat_sequencer #(
  parameter int DATA_WIDTH_IN  = 64,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int ID_WIDTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  dwc_upconv_rchan_beat_sequencer_if.master     bus,
  output logic                                  busy,
  output logic [15:0]                           stall_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, BEAT} state_t;

  localparam logic [5:0] MAX_SRC = 6'(DATA_WIDTH_IN / DATA_WIDTH_OUT - 1);

  state_t              state_reg, state_next;
  logic [9:0]          addr_reg, mask_reg;
  logic [ID_WIDTH-1:0] id_reg;
  logic [7:0]          len_reg, beat_cnt_reg;
  logic                fixed_reg, wrap_reg;
  logic [4:0]          to_wrap_reg, wrap_cnt_reg;
  logic [5:0]          top_reg, rd_src_reg;

  logic in_beat, rvalid, acc, last_beat, wrap_hit, top_hit;

  assign in_beat   = (state_reg == BEAT);
  assign rvalid    = in_beat & bus.slv_data_valid;
  assign acc       = rvalid & bus.mst_rready;
  assign last_beat = in_beat & (beat_cnt_reg == len_reg);
  assign wrap_hit  = wrap_reg & (wrap_cnt_reg == 5'd0);
  assign top_hit   = (rd_src_reg == top_reg);

  assign bus.mst_rvalid   = rvalid;
  assign bus.mst_rlast    = last_beat;
  assign bus.mst_rid      = id_reg;
  assign bus.rd_src       = rd_src_reg;
  // A wide word is released when its last narrow slice goes out, or when the burst ends
  assign bus.slv_data_pop = acc & (fixed_reg | wrap_hit | top_hit | last_beat);
  assign busy             = (state_reg != IDLE);

  // Upper address/mask bits and the width ratio do not steer the 6-bit slice index
  logic unused_cfg;
  assign unused_cfg = ^{MAX_SRC, addr_reg[9:6], mask_reg[9:6]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus.cmd_rd_en = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!bus.cmd_empty) begin
          bus.cmd_rd_en = 1'b1;
          state_next    = LOAD;
        end
      end
      LOAD:    state_next = BEAT;
      BEAT:    if (acc && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg     <= '0;
      mask_reg     <= '0;
      id_reg       <= '0;
      len_reg      <= '0;
      fixed_reg    <= 1'b0;
      wrap_reg     <= 1'b0;
      to_wrap_reg  <= '0;
      top_reg      <= '0;
      beat_cnt_reg <= '0;
      wrap_cnt_reg <= '0;
      rd_src_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!bus.cmd_empty) begin
            addr_reg    <= bus.cmd_addr;
            mask_reg    <= bus.cmd_mask;
            id_reg      <= bus.cmd_id;
            len_reg     <= bus.cmd_len;
            fixed_reg   <= bus.cmd_fixed;
            wrap_reg    <= bus.cmd_wrap;
            to_wrap_reg <= bus.cmd_to_wrap;
            top_reg     <= bus.cmd_src_top;
          end
        end
        LOAD: begin
          rd_src_reg   <= addr_reg[5:0] & mask_reg[5:0];
          beat_cnt_reg <= 8'd0;
          wrap_cnt_reg <= to_wrap_reg;
        end
        BEAT: begin
          if (acc && !last_beat) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
            // FIXED bursts keep re-reading the same slice of successive words
            if (!fixed_reg) begin
              if (wrap_hit) begin
                rd_src_reg   <= 6'd0;
                wrap_cnt_reg <= to_wrap_reg;
              end else begin
                rd_src_reg <= top_hit ? 6'd0 : rd_src_reg + 6'd1;
                if (wrap_reg) wrap_cnt_reg <= wrap_cnt_reg - 5'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DWC_UPCONV_RSEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_reg <= 16'h0000;
    else if (rvalid && !bus.mst_rready && stall_cnt_reg != 16'hFFFF)
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dwc_upconv_rchan_beat_sequencer.sv
// Scoreboard bench for the read-data beat sequencer: directed bursts, monitor checks every accepted beat.
module tb_dwc_upconv_rchan_beat_sequencer;

  localparam int ID_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] stall_cnt;

  dwc_upconv_rchan_beat_sequencer_if #(.ID_WIDTH(ID_W)) bus ();

  dwc_upconv_rchan_beat_sequencer #(
    .DATA_WIDTH_IN (64),
    .DATA_WIDTH_OUT(32),
    .ID_WIDTH      (ID_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]      src;
    logic            last;
    logic            pop;
    logic [ID_W-1:0] id;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [5:0] s, input logic l, input logic p, input logic [ID_W-1:0] id);
    exp_q.push_back('{src: s, last: l, pop: p, id: id});
  endtask

  // Monitor: every accepted beat is compared against the head of the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.mst_rvalid === 1'b1 && bus.mst_rready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("beat: rd_src=%0d rlast=%0b pop=%0b rid=%0h", bus.rd_src, bus.mst_rlast,
                 bus.slv_data_pop, bus.mst_rid);
        check("beat_rd_src", bus.rd_src, mon_e.src);
        check("beat_rlast", bus.mst_rlast, mon_e.last);
        check("beat_pop", bus.slv_data_pop, mon_e.pop);
        check("beat_rid", bus.mst_rid, mon_e.id);
      end
    end
    if (rst === 1'b1 && bus.slv_data_pop === 1'b1)
      check("pop_needs_acc", bus.mst_rvalid & bus.mst_rready & bus.slv_data_valid, 1);
  end

  // Present a command; returns at the negedge of the LOAD cycle
  task automatic issue_cmd(input logic [9:0] addr, input logic [ID_W-1:0] id, input logic [7:0] len,
                           input logic fixed, input logic wrap, input logic [4:0] to_wrap,
                           input logic [9:0] mask, input logic [5:0] top);
    @(posedge clk); #1;
    bus.cmd_addr    = addr;
    bus.cmd_id      = id;
    bus.cmd_len     = len;
    bus.cmd_fixed   = fixed;
    bus.cmd_wrap    = wrap;
    bus.cmd_to_wrap = to_wrap;
    bus.cmd_mask    = mask;
    bus.cmd_src_top = top;
    bus.cmd_empty   = 1'b0;
    @(negedge clk);
    check("cmd_rd_en", bus.cmd_rd_en, 1);
    $display("cmd: addr=%0d id=%0h len=%0d fixed=%0b wrap=%0b to_wrap=%0d top=%0d",
             addr, id, len, fixed, wrap, to_wrap, top);
    @(posedge clk); #1;
    bus.cmd_empty = 1'b1;
    @(negedge clk);
    check("load_busy", busy, 1);
    check("load_rvalid", bus.mst_rvalid, 0);
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) $display("FAIL %s_timeout: busy still high after 200 cycles", name);
    check({name, "_done"}, done, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  logic [5:0]      hold_src;
  logic            hold_last;
  logic [ID_W-1:0] hold_id;
  bit              seen;

  initial begin
    rst                = 1'b0;
    bus.cmd_empty      = 1'b1;
    bus.cmd_addr       = '0;
    bus.cmd_id         = '0;
    bus.cmd_len        = '0;
    bus.cmd_fixed      = 1'b0;
    bus.cmd_wrap       = 1'b0;
    bus.cmd_to_wrap    = '0;
    bus.cmd_mask       = '0;
    bus.cmd_src_top    = '0;
    bus.slv_data_valid = 1'b1;
    bus.mst_rready     = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rvalid", bus.mst_rvalid, 0);
    check("rst_pop", bus.slv_data_pop, 0);
    check("rst_rd_src", bus.rd_src, 0);
    check("rst_rlast", bus.mst_rlast, 0);
    check("rst_rid", bus.mst_rid, 0);
    check("rst_cmd_rd_en", bus.cmd_rd_en, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // INCR len=7, two slices per word
    for (int i = 0; i < 8; i++) push(6'(i % 2), i == 7, (i % 2) == 1, 4'h5);
    issue_cmd(10'd0, 4'h5, 8'd7, 1'b0, 1'b0, 5'd0, 10'h001, 6'd1);
    @(negedge clk);
    check("first_rvalid_latency", bus.mst_rvalid, 1);
    wait_done("incr8");

    // INCR len=2 starting mid-word, FIFO initially empty
    bus.slv_data_valid = 1'b0;
    push(6'd1, 1'b0, 1'b1, 4'h3);
    push(6'd0, 1'b0, 1'b0, 4'h3);
    push(6'd1, 1'b1, 1'b1, 4'h3);
    issue_cmd(10'd1, 4'h3, 8'd2, 1'b0, 1'b0, 5'd0, 10'h03F, 6'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("novalid_rvalid", bus.mst_rvalid, 0);
      check("novalid_pop", bus.slv_data_pop, 0);
      check("novalid_busy", busy, 1);
    end
    @(posedge clk); #1;
    bus.slv_data_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mst_rvalid && bus.mst_rready && bus.mst_rlast) seen = 1'b1;
    end
    check("incr3_rlast_seen", seen, 1);
    check("incr3_busy_at_last", busy, 1);
    @(negedge clk);
    check("incr3_busy_fall", busy, 0);
    wait_done("incr3");

    // FIXED len=3
    for (int i = 0; i < 4; i++) push(6'd1, i == 3, 1'b1, 4'h2);
    issue_cmd(10'd1, 4'h2, 8'd3, 1'b1, 1'b0, 5'd0, 10'h03F, 6'd1);
    wait_done("fixed4");

    // WRAP len=3, four slices per word
    push(6'd2, 1'b0, 1'b0, 4'h6);
    push(6'd3, 1'b0, 1'b1, 4'h6);
    push(6'd0, 1'b0, 1'b0, 4'h6);
    push(6'd1, 1'b1, 1'b1, 4'h6);
    issue_cmd(10'd2, 4'h6, 8'd3, 1'b0, 1'b1, 5'd1, 10'h03F, 6'd3);
    wait_done("wrap4");

    // rready toggling, equal widths so every beat pops
    for (int i = 0; i < 4; i++) push(6'd0, i == 3, 1'b1, 4'hC);
    issue_cmd(10'd0, 4'hC, 8'd3, 1'b0, 1'b0, 5'd0, 10'h000, 6'd0);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      #1 bus.mst_rready = 1'b0;
      @(negedge clk);
      check("stall_rvalid", bus.mst_rvalid, 1);
      check("stall_pop", bus.slv_data_pop, 0);
      hold_src  = bus.rd_src;
      hold_last = bus.mst_rlast;
      hold_id   = bus.mst_rid;
      @(posedge clk); #1;
      bus.mst_rready = 1'b1;
      @(negedge clk);
      check("hold_rd_src", bus.rd_src, hold_src);
      check("hold_rlast", bus.mst_rlast, hold_last);
      check("hold_rid", bus.mst_rid, hold_id);
      @(posedge clk);
    end
    wait_done("toggle4");
`ifdef DWC_UPCONV_RSEQ_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 3);
`else
    check("stall_cnt", stall_cnt, 0);
`endif

    // Reset during beat 2 of a long burst
    push(6'd0, 1'b0, 1'b0, 4'h9);
    push(6'd1, 1'b0, 1'b1, 4'h9);
    issue_cmd(10'd0, 4'h9, 8'd7, 1'b0, 1'b0, 5'd0, 10'h001, 6'd1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_rvalid", bus.mst_rvalid, 0);
    check("midrst_pop", bus.slv_data_pop, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_src", bus.rd_src, 0);
    check("midrst_rid", bus.mst_rid, 0);
    check("midrst_stall_cnt", stall_cnt, 0);
    check("midrst_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single-beat burst after reset
    push(6'd1, 1'b1, 1'b1, 4'hA);
    issue_cmd(10'd1, 4'hA, 8'd0, 1'b0, 1'b0, 5'd0, 10'h03F, 6'd1);
    wait_done("single");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
